// File: rtl/epp_pkg.sv
// epp_pkg: shared EPP command encodings and host state enumeration.
package epp_pkg;
  typedef enum logic [1:0] {
    OP_AW = 2'd0,
    OP_DW = 2'd1,
    OP_AR = 2'd2,
    OP_DR = 2'd3
  } epp_op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DONE
  } epp_state_e;
  localparam int TO_W = 10;
endpackage

// File: rtl/epp_sync2.sv
// epp_sync2: two-flop synchronizer with asynchronous reset.
module epp_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {r_meta, r_q} <= 2'b00;
    else {r_meta, r_q} <= {i_d, r_meta};
  end
  assign o_q = r_q;
endmodule

// File: rtl/epp_host.sv
// epp_host: EPP bus master sequencing address/data reads and writes.
// Optional watchdog on every handshake phase: EPP_HOST_TIMEOUT_EN.
module epp_host import epp_pkg::*; #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       EppAstb_out,
  output logic       EppDstb_out,
  output logic       EppWR_out,
  input  logic       EppWait_in,
  input  logic [7:0] EppDB_in,
  output logic [7:0] EppDB_out,
  output logic       EppDB_oe
);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  epp_state_e r_state, w_nxt;
  logic [1:0] r_op, w_op;
  logic [7:0] r_wd, w_wd;
  logic [SW-1:0] r_scnt;
  logic w_wait, w_acc, w_setup_done, w_to, w_to_fire;
  logic r_astb, r_dstb, r_wr, r_oe, r_valid, r_to;
  logic [7:0] r_db, r_rdata;

  epp_sync2 u_sync (.clk(clk), .rst(rst), .i_d(EppWait_in), .o_q(w_wait));

  assign cmd_ready    = (r_state == S_IDLE) && !rst;
  assign w_acc        = cmd_valid && cmd_ready;
  assign w_op         = w_acc ? cmd_op : r_op;
  assign w_wd         = w_acc ? cmd_wdata : r_wd;
  assign w_setup_done = r_scnt == SW'(SETUP_CYCLES - 1);

`ifdef EPP_HOST_TIMEOUT_EN
  logic [TO_W-1:0] r_tcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tcnt <= '0;
    else r_tcnt <= (w_nxt != r_state) ? '0 : r_tcnt + 1'b1;
  end
  assign w_to = (r_state inside {S_SETUP, S_STROBE, S_RELEASE}) &&
                (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_to;
  assign w_unused_to = TIMEOUT_CYCLES[0];
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  end

  // A normal handshake step always wins over a coincident timeout.
  always_comb begin
    w_nxt     = r_state;
    w_to_fire = 1'b0;
    case (r_state)
      S_IDLE: w_nxt = w_acc ? S_SETUP : S_IDLE;
      S_SETUP: begin
        w_nxt     = (w_setup_done && !w_wait) ? S_STROBE : (w_to ? S_DONE : S_SETUP);
        w_to_fire = !(w_setup_done && !w_wait) && w_to;
      end
      S_STROBE: begin
        w_nxt     = w_wait ? S_RELEASE : (w_to ? S_DONE : S_STROBE);
        w_to_fire = !w_wait && w_to;
      end
      S_RELEASE: begin
        w_nxt     = (!w_wait || w_to) ? S_DONE : S_RELEASE;
        w_to_fire = w_wait && w_to;
      end
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= 2'd0;
      r_wd <= 8'd0;
      r_scnt <= '0;
    end else begin
      r_op <= w_op;
      r_wd <= w_wd;
      r_scnt <= (r_state != S_SETUP) ? '0 : (w_setup_done ? r_scnt : r_scnt + 1'b1);
    end
  end

  // Pad controls are registered from the next state so strobes are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_astb  <= 1'b1;
      r_dstb  <= 1'b1;
      r_wr    <= 1'b1;
      r_oe    <= 1'b0;
      r_db    <= 8'd0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      r_astb  <= !(w_nxt == S_STROBE && !w_op[0]);
      r_dstb  <= !(w_nxt == S_STROBE && w_op[0]);
      r_wr    <= (w_nxt == S_IDLE) ? 1'b1 : (w_nxt == S_SETUP) ? w_op[1] : r_wr;
      r_oe    <= (w_nxt == S_IDLE) ? 1'b0 : (w_nxt == S_SETUP) ? !w_op[1] : r_oe;
      r_db    <= (w_nxt == S_IDLE) ? 8'd0 : (w_nxt == S_SETUP) ? (w_op[1] ? 8'd0 : w_wd) : r_db;
      r_valid <= w_nxt == S_DONE;
      r_to    <= w_to_fire;
      r_rdata <= (w_acc || w_to_fire) ? 8'd0 :
                 (r_state == S_STROBE && w_wait && r_op[1]) ? EppDB_in : r_rdata;
    end
  end

  assign EppAstb_out = r_astb;
  assign EppDstb_out = r_dstb;
  assign EppWR_out   = r_wr;
  assign EppDB_oe    = r_oe;
  assign EppDB_out   = r_db;
  assign rsp_valid   = r_valid;
  assign rsp_timeout = r_to;
  assign rsp_rdata   = r_rdata;
endmodule

// File: tb/tb_epp_host.sv
// tb_epp_host: scoreboard bench for epp_host against a simple EPP peripheral model.
module tb_epp_host;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_timeout, EppAstb_out, EppDstb_out, EppWR_out, EppDB_oe;
  logic [7:0] rsp_rdata, EppDB_out, EppDB_in;
  logic p_wait;

  always #5 clk = ~clk;

  epp_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .EppAstb_out(EppAstb_out), .EppDstb_out(EppDstb_out),
    .EppWR_out(EppWR_out), .EppWait_in(p_wait), .EppDB_in(EppDB_in),
    .EppDB_out(EppDB_out), .EppDB_oe(EppDB_oe)
  );

  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [7:0] rd; logic to;} rsp_t;
  rsp_t q[$];
  rsp_t e_r;
  logic [1:0] cur_op = 0;
  logic [7:0] cur_wd = 0;
  logic tie0 = 0, hold1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Peripheral: raises wait 2 cycles after a strobe falls, drops it 1 cycle after release.
  logic [7:0] p_addr;
  logic [7:0] p_mem[256];
  logic [1:0] p_cnt;
  assign EppDB_in = !EppAstb_out ? p_addr : p_mem[p_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_wait <= 0; p_cnt <= 0; p_addr <= 0;
    end else if (tie0) p_wait <= 0;
    else if (hold1) p_wait <= 1;
    else if (!EppAstb_out || !EppDstb_out) begin
      if (!p_wait) begin
        if (p_cnt == 1) begin
          p_wait <= 1;
          if (!EppWR_out) begin
            if (!EppAstb_out) p_addr <= EppDB_out;
            else p_mem[p_addr] <= EppDB_out;
          end
        end else p_cnt <= p_cnt + 1;
      end
    end else begin
      p_cnt <= 0; p_wait <= 0;
    end
  end

  logic prev_v = 0, prev_any = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0; prev_any = 0;
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e_r = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e_r.rd);
          chk("rsp_timeout", rsp_timeout, e_r.to);
        end
        chk("ready_in_done", cmd_ready, 0);
        chk("strobes_high_done", {EppAstb_out, EppDstb_out}, 2'b11);
      end
      if (prev_v) chk("ready_after_done", cmd_ready, 1);
      if (!EppAstb_out || !EppDstb_out) begin
        chk("no_overlap", EppAstb_out | EppDstb_out, 1);
        chk("ready_busy", cmd_ready, 0);
        chk("wr_strobe", EppWR_out, cur_op[1]);
        chk("oe_strobe", EppDB_oe, !cur_op[1]);
        if (!prev_any) begin
          chk("strobe_sel", {EppAstb_out, EppDstb_out}, cur_op[0] ? 2'b10 : 2'b01);
          if (!cur_op[1]) chk("db_out", EppDB_out, cur_wd);
          chk("no_strobe_while_wait", hold1, 0);
        end
      end
      prev_v = rsp_valid;
      prev_any = !EppAstb_out || !EppDstb_out;
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] erd,
                      input logic eto, input bit push, input bit hold);
    int n = 0;
    cmd_op = op; cmd_wdata = wd; cmd_valid = 1;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    if (push) q.push_back('{erd, eto});
    @(negedge clk);
    cur_op = op; cur_wd = wd;
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) begin
      chk("drain_timeout", 0, 1);
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_astb", EppAstb_out, 1);
    chk("rst_dstb", EppDstb_out, 1);
    chk("rst_wr", EppWR_out, 1);
    chk("rst_oe", EppDB_oe, 0);
    chk("rst_db", EppDB_out, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 0;
    @(negedge clk);
    send(2'd0, 8'h05, 8'h00, 0, 1, 0); wait_idle();
    send(2'd1, 8'hA7, 8'h00, 0, 1, 0); wait_idle();
    send(2'd3, 8'h00, 8'hA7, 0, 1, 0); wait_idle();
    send(2'd0, 8'h02, 8'h00, 0, 1, 0); wait_idle();
    send(2'd1, 8'h3C, 8'h00, 0, 1, 0); wait_idle();
    send(2'd0, 8'h02, 8'h00, 0, 1, 0); wait_idle();
    send(2'd3, 8'h00, 8'h3C, 0, 1, 0); wait_idle();
    send(2'd2, 8'h00, 8'h02, 0, 1, 0); wait_idle();
    hold1 = 1;
    repeat (4) @(negedge clk);
    send(2'd0, 8'h09, 8'h00, 0, 1, 0);
    repeat (10) @(negedge clk);
    chk("held_setup_ready", cmd_ready, 0);
    chk("held_setup_strobes", {EppAstb_out, EppDstb_out}, 2'b11);
    hold1 = 0;
    wait_idle();
    send(2'd0, 8'h07, 8'h00, 0, 1, 1);
    send(2'd1, 8'h5A, 8'h00, 0, 1, 1);
    send(2'd3, 8'h00, 8'h5A, 0, 1, 0);
    wait_idle();
`ifdef EPP_HOST_TIMEOUT_EN
    begin
      int lo = 0, n = 0;
      tie0 = 1;
      send(2'd1, 8'h33, 8'h00, 1, 1, 0);
      while (!rsp_valid && n < 3000) begin
        if (!EppDstb_out) lo++;
        @(negedge clk);
        n++;
      end
      chk("timeout_len", lo, 1023);
      wait_idle();
      tie0 = 0;
    end
`endif
    begin
      int n = 0;
      send(2'd1, 8'h11, 8'h00, 0, 0, 0);
      while (EppDstb_out && n < 100) begin @(negedge clk); n++; end
      chk("reached_strobe", EppDstb_out, 0);
      rst = 1;
      #1;
      chk("rst_mid_strobes", {EppAstb_out, EppDstb_out}, 2'b11);
      chk("rst_mid_oe", EppDB_oe, 0);
      chk("rst_mid_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", cmd_ready, 1);
      @(negedge clk);
    end
    send(2'd0, 8'h07, 8'h00, 0, 1, 0); wait_idle();
    send(2'd3, 8'h00, 8'h5A, 0, 1, 0); wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end
endmodule
